// File: rtl/uart_fifo_link_if.sv
// uart_fifo_link_if
//   Fabric-side byte handshakes of the UART link, one valid/ready pair per
//   direction.
//   master : fabric side (drives tx_data/tx_valid and rx_ready)
//   slave  : link side   (drives tx_ready, rx_data and rx_valid)
//   Parameter DATA_BITS must match the DATA_BITS of the attached link.
interface uart_fifo_link_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, rx_data, rx_valid
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, rx_data, rx_valid
  );
endinterface

// File: rtl/uart_fifo_link.sv
// uart_fifo_link
//   Full-duplex UART: TX FIFO -> serializer, rx pin -> 2-FF sync ->
//   deserializer -> RX FIFO. Frame is start, DATA_BITS data (LSB first),
//   optional parity, one stop. Sticky error flags for framing, parity and
//   RX FIFO overrun.
//
//   Optional build macro UART_LOOPBACK_EN: when defined, loopback=1 feeds the
//   internal serial output into the receiver and parks the tx pin high.
//   Without it the loopback input is ignored.
//
//   Ports
//     clk, rst_n        system clock, asynchronous active-low reset
//     bus (slave)       tx_data/tx_valid/tx_ready, rx_data/rx_valid/rx_ready
//     tx_level/rx_level FIFO occupancy
//     tx / rx           serial line out (idle high) / in (asynchronous)
//     tx_busy/rx_busy   frame in progress
//     rx_overrun, rx_frame_err, rx_parity_err   sticky flags
//     err_clr           one-cycle pulse clears sticky flags (set wins)
//     loopback          internal loopback select
//
//   FSM states (both directions)
//     state   | meaning
//     S_IDLE  | line idle; TX pops FIFO head, RX waits for falling edge
//     S_START | start bit (RX: half-bit wait then glitch check)
//     S_DATA  | data bits, LSB first
//     S_PAR   | parity bit (only when PARITY != 0)
//     S_STOP  | stop bit (RX: decide push / error at its midpoint)
module uart_fifo_link #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 16,
  localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_fifo_link_if.slave bus,
  output logic [LW-1:0] tx_level,
  output logic [LW-1:0] rx_level,
  output logic          tx,
  input  logic          rx,
  output logic          tx_busy,
  output logic          rx_busy,
  output logic          rx_overrun,
  output logic          rx_frame_err,
  output logic          rx_parity_err,
  input  logic          err_clr,
  input  logic          loopback
);
  localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS);

  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_BIT  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic          PAR_ODD  = (PARITY == 1);
  localparam bit            HAS_PAR  = (PARITY != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  // ---------------- TX FIFO ----------------
  logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]        tx_wp, tx_rp;
  logic                 tx_push, tx_pop;
  state_t               tx_state;

  assign bus.tx_ready = (tx_level != FULL);
  assign tx_push      = bus.tx_valid && bus.tx_ready;
  assign tx_pop       = (tx_state == S_IDLE) && (tx_level != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      if (tx_push && !tx_pop)      tx_level <= tx_level + LW'(1);
      else if (!tx_push && tx_pop) tx_level <= tx_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= bus.tx_data;
  end

  // ---------------- TX serializer ----------------
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bit;
  logic [DATA_BITS-1:0] tx_sh;
  logic                 tx_par;
  logic                 tx_line;
  logic                 tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else if (tx_state == S_IDLE) begin
      tx_line <= 1'b1;
      if (tx_pop) begin
        tx_sh    <= tx_mem[tx_rp];
        tx_par   <= (^tx_mem[tx_rp]) ^ PAR_ODD;
        tx_cnt   <= CNT_BIT;
        tx_line  <= 1'b0;
        tx_state <= S_START;
      end
    end else if (tx_cnt != '0) begin
      tx_cnt <= tx_cnt - CW'(1);
    end else begin
      tx_cnt <= CNT_BIT;
      case (tx_state)
        S_START: begin
          tx_line  <= tx_sh[0];
          tx_sh    <= tx_sh >> 1;
          tx_bit   <= LAST_BIT;
          tx_state <= S_DATA;
        end
        S_DATA: begin
          if (tx_bit != '0) begin
            tx_line <= tx_sh[0];
            tx_sh   <= tx_sh >> 1;
            tx_bit  <= tx_bit - BW'(1);
          end else if (HAS_PAR) begin
            tx_line  <= tx_par;
            tx_state <= S_PAR;
          end else begin
            tx_line  <= 1'b1;
            tx_state <= S_STOP;
          end
        end
        S_PAR: begin
          tx_line  <= 1'b1;
          tx_state <= S_STOP;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Output retiming stage: the line drops one clock after the pop, which keeps
  // the pop-to-start and stop-to-next-pop spacing of a single idle clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tx_q <= 1'b1;
    else        tx_q <= tx_line;
  end

  assign tx_busy = (tx_state != S_IDLE);

  // ---------------- Loopback select ----------------
  logic rx_src;
`ifdef UART_LOOPBACK_EN
  assign rx_src = loopback ? tx_q : rx;
  assign tx     = loopback ? 1'b1 : tx_q;
`else
  logic unused_loopback;
  assign unused_loopback = loopback;
  assign rx_src          = rx;
  assign tx              = tx_q;
`endif

  // ---------------- RX synchroniser ----------------
  logic rx_s1, rx_s2, rx_prev, rx_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= rx_src;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  assign rx_fall = rx_prev && !rx_s2;

  // ---------------- RX deserializer ----------------
  state_t               rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bit;
  logic [DATA_BITS-1:0] rx_sh;
  logic                 rx_pbit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_sh    <= '0;
      rx_pbit  <= 1'b0;
    end else if (rx_state == S_IDLE) begin
      if (rx_fall) begin
        rx_cnt   <= CNT_HALF;
        rx_state <= S_START;
      end
    end else if (rx_cnt != '0) begin
      rx_cnt <= rx_cnt - CW'(1);
    end else begin
      rx_cnt <= CNT_BIT;
      case (rx_state)
        S_START: begin
          if (rx_s2) begin
            rx_state <= S_IDLE;
          end else begin
            rx_bit   <= LAST_BIT;
            rx_state <= S_DATA;
          end
        end
        S_DATA: begin
          rx_sh <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          if (rx_bit != '0)  rx_bit   <= rx_bit - BW'(1);
          else if (HAS_PAR)  rx_state <= S_PAR;
          else               rx_state <= S_STOP;
        end
        S_PAR: begin
          rx_pbit  <= rx_s2;
          rx_state <= S_STOP;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  assign rx_busy = (rx_state != S_IDLE);

  // Frame outcome at the stop-bit sample; first matching cause wins.
  logic rx_done, rx_par_ok, rx_full;
  logic frame_set, par_set, ovr_set, rx_push, rx_pop;

  assign rx_done   = (rx_state == S_STOP) && (rx_cnt == '0);
  assign rx_par_ok = !HAS_PAR || (rx_pbit == ((^rx_sh) ^ PAR_ODD));
  assign rx_full   = (rx_level == FULL);
  assign frame_set = rx_done && !rx_s2;
  assign par_set   = rx_done && rx_s2 && !rx_par_ok;
  assign ovr_set   = rx_done && rx_s2 && rx_par_ok && rx_full;
  assign rx_push   = rx_done && rx_s2 && rx_par_ok && !rx_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_overrun    <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_parity_err <= 1'b0;
    end else begin
      rx_overrun    <= ovr_set   || (rx_overrun    && !err_clr);
      rx_frame_err  <= frame_set || (rx_frame_err  && !err_clr);
      rx_parity_err <= par_set   || (rx_parity_err && !err_clr);
    end
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]        rx_wp, rx_rp;

  assign bus.rx_valid = (rx_level != '0);
  assign bus.rx_data  = bus.rx_valid ? rx_mem[rx_rp] : '0;
  assign rx_pop       = bus.rx_valid && bus.rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop)  rx_rp <= rx_rp + AW'(1);
      if (rx_push && !rx_pop)      rx_level <= rx_level + LW'(1);
      else if (!rx_push && rx_pop) rx_level <= rx_level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_sh;
  end
endmodule

// File: tb/tb_uart_fifo_link.sv
// tb_uart_fifo_link
//   Directed bench with two links: A (8N1, DIV=434, depth 16) for the serial
//   waveform check, B (8E1, DIV=16, depth 4) for loopback, RX error handling,
//   overrun and mid-frame reset. Loopback on B is wired in the bench from
//   tx to rx so it works with or without UART_LOOPBACK_EN.
module tb_uart_fifo_link;
  localparam int DIV_A = 434;
  localparam int DIV_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, err_clr, rx_drv, lb_sel;

  uart_fifo_link_if #(.DATA_BITS(8)) ifa ();
  uart_fifo_link_if #(.DATA_BITS(8)) ifb ();

  logic [4:0] tx_level_a, rx_level_a;
  logic       tx_a, tx_busy_a, rx_busy_a, ov_a, fe_a, pe_a;
  logic [2:0] tx_level_b, rx_level_b;
  logic       tx_b, rx_b, tx_busy_b, rx_busy_b, ov_b, fe_b, pe_b;

  assign rx_b = lb_sel ? tx_b : rx_drv;

  uart_fifo_link #(
    .CLK_HZ(50_000_000), .BAUD(115_200), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave),
    .tx_level(tx_level_a), .rx_level(rx_level_a),
    .tx(tx_a), .rx(1'b1), .tx_busy(tx_busy_a), .rx_busy(rx_busy_a),
    .rx_overrun(ov_a), .rx_frame_err(fe_a), .rx_parity_err(pe_a),
    .err_clr(err_clr), .loopback(1'b0)
  );

  uart_fifo_link #(
    .CLK_HZ(1_600_000), .BAUD(100_000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave),
    .tx_level(tx_level_b), .rx_level(rx_level_b),
    .tx(tx_b), .rx(rx_b), .tx_busy(tx_busy_b), .rx_busy(rx_busy_b),
    .rx_overrun(ov_b), .rx_frame_err(fe_b), .rx_parity_err(pe_b),
    .err_clr(err_clr), .loopback(1'b0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one 8E1-shaped frame on rx with explicit parity/stop bit values.
  task automatic send_frame(input logic [7:0] d, input logic pb, input logic sb);
    logic [10:0] bits;
    bits = {sb, pb, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx_drv = bits[i];
      repeat (DIV_B) @(posedge clk);
      #1;
    end
    rx_drv = 1'b1;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  task automatic pop_b();
    @(negedge clk); ifb.rx_ready = 1'b1;
    @(negedge clk); ifb.rx_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] exp_a, samp_a;
    logic [7:0] lb_vals [3];
    logic [7:0] rxw [3];
    logic [7:0] ovr_vals [5];
    int first_low, busy_cnt, bit_bad, got, pushed, lows, k2;
    logic exp_bit, hs;

    exp_a = 10'b1101001010;  // start..stop for 0xA5, index 0 = start bit
    lb_vals[0] = 8'h00; lb_vals[1] = 8'hFF; lb_vals[2] = 8'h3C;
    ovr_vals[0] = 8'h11; ovr_vals[1] = 8'h22; ovr_vals[2] = 8'h33;
    ovr_vals[3] = 8'h44; ovr_vals[4] = 8'h55;

    ifa.tx_data = '0; ifa.tx_valid = 1'b0; ifa.rx_ready = 1'b0;
    ifb.tx_data = '0; ifb.tx_valid = 1'b0; ifb.rx_ready = 1'b0;
    err_clr = 1'b0; rx_drv = 1'b1; lb_sel = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_a", tx_a, 1);
    check("rst_tx_b", tx_b, 1);
    check("rst_busy_b", {tx_busy_b, rx_busy_b}, 0);
    check("rst_tx_ready_b", ifb.tx_ready, 1);
    check("rst_rx_valid_b", ifb.rx_valid, 0);
    check("rst_rx_data_b", ifb.rx_data, 0);
    check("rst_levels_b", {tx_level_b, rx_level_b}, 0);
    check("rst_flags_b", {ov_b, fe_b, pe_b}, 0);
    check("rst_levels_a", {tx_level_a, rx_level_a}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // ---- A: 0xA5 waveform, 8N1, DIV=434 ----
    ifa.tx_data = 8'hA5; ifa.tx_valid = 1'b1;
    @(posedge clk); #1;
    check("a_level_push", tx_level_a, 1);
    @(negedge clk); ifa.tx_valid = 1'b0;
    first_low = -1; busy_cnt = 0; bit_bad = 0; samp_a = '0;
    for (int k = 1; k <= 4400; k++) begin
      @(posedge clk); #1;
      if (tx_busy_a) busy_cnt++;
      if (first_low < 0 && !tx_a) first_low = k;
      if (k >= 2 && k < 2 + 10 * DIV_A) exp_bit = exp_a[(k - 2) / DIV_A];
      else exp_bit = 1'b1;
      if (tx_a !== exp_bit) bit_bad++;
      if (k >= 2 && k < 2 + 10 * DIV_A && ((k - 2) % DIV_A) == DIV_A / 2)
        samp_a[(k - 2) / DIV_A] = tx_a;
    end
    check("a_tx_latency", first_low, 2);
    check("a_busy_clocks", busy_cnt, 4340);
    check("a_bit_errors", bit_bad, 0);
    check("a_bits_mid", samp_a, exp_a);
    check("a_level_end", tx_level_a, 0);

    // ---- B: loopback of three words ----
    lb_sel = 1'b1; ifb.rx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); ifb.tx_data = lb_vals[i]; ifb.tx_valid = 1'b1;
    end
    @(negedge clk); ifb.tx_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 1500 && got < 3; c++) begin
      @(negedge clk);
      if (ifb.rx_valid) begin
        rxw[got] = ifb.rx_data;
        got++;
      end
    end
    check("lb_count", got, 3);
    check("lb_word0", rxw[0], 8'h00);
    check("lb_word1", rxw[1], 8'hFF);
    check("lb_word2", rxw[2], 8'h3C);
    check("lb_flags", {ov_b, fe_b, pe_b}, 0);
    repeat (40) @(negedge clk);
    lb_sel = 1'b0; ifb.rx_ready = 1'b0;
    repeat (4) @(negedge clk);

    // ---- B: framing error then good frame ----
    send_frame(8'h55, 1'b0, 1'b0);
    check("fe_level", rx_level_b, 0);
    check("fe_flag", fe_b, 1);
    send_frame(8'h12, 1'b0, 1'b1);
    check("fe_next_level", rx_level_b, 1);
    check("fe_next_data", ifb.rx_data, 8'h12);
    pulse_clr();
    check("fe_clr", fe_b, 0);
    pop_b();
    check("fe_pop_level", rx_level_b, 0);

    // ---- B: parity error (even parity) ----
    send_frame(8'h07, 1'b0, 1'b1);
    check("pe_flag", pe_b, 1);
    check("pe_level", rx_level_b, 0);
    send_frame(8'h07, 1'b1, 1'b1);
    check("pe_good_level", rx_level_b, 1);
    check("pe_good_data", ifb.rx_data, 8'h07);
    check("pe_other_flags", {ov_b, fe_b}, 0);
    check("pe_sticky", pe_b, 1);
    pulse_clr();
    pop_b();

    // ---- B: overrun with depth 4 ----
    for (int i = 0; i < 5; i++) send_frame(ovr_vals[i], 1'b0, 1'b1);
    check("ov_level", rx_level_b, 4);
    check("ov_flag", ov_b, 1);
    check("ov_other_flags", {fe_b, pe_b}, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ov_pop_data", ifb.rx_data, ovr_vals[i]);
      ifb.rx_ready = 1'b1;
    end
    @(negedge clk); ifb.rx_ready = 1'b0;
    check("ov_empty", ifb.rx_valid, 0);
    pulse_clr();
    check("ov_clr", ov_b, 0);

    // ---- B: eight pushes, then reset mid-frame ----
    pushed = 0;
    for (int c = 0; c < 3000 && pushed < 8; c++) begin
      @(negedge clk);
      ifb.tx_data = 8'(pushed + 1);
      ifb.tx_valid = 1'b1;
      hs = ifb.tx_ready;
      @(posedge clk);
      if (hs) pushed++;
    end
    @(negedge clk); ifb.tx_valid = 1'b0;
    check("tx8_pushed", pushed, 8);
    repeat (50) @(negedge clk);
    check("tx8_busy_pre", tx_busy_b, 1);
    rst_n = 1'b0;
    #1;
    check("tx8_rst_tx", tx_b, 1);
    check("tx8_rst_level", tx_level_b, 0);
    check("tx8_rst_busy", tx_busy_b, 0);
    @(negedge clk); rst_n = 1'b1;
    lows = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (!tx_b || tx_busy_b) lows++;
    end
    check("tx8_idle_after", lows, 0);
    ifb.tx_data = 8'h5A; ifb.tx_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); ifb.tx_valid = 1'b0;
    k2 = -1;
    for (int k = 1; k <= 20 && k2 < 0; k++) begin
      @(posedge clk); #1;
      if (!tx_b) k2 = k;
    end
    check("tx8_restart_latency", k2, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_fifo_link.md
# uart_fifo_link

Parametrised full-duplex UART link: a TX serializer and an RX deserializer, each behind its own synchronous FIFO, with valid/ready byte interfaces on the fabric side. It replaces the fixed 8N1 sender/receiver/FIFO trio used under the board-level communication top. It adds configurable word width, parity, FIFO depth and baud rate, plus sticky error reporting. Button, parser and display logic stay outside and attach to the TX and RX handshakes.

## Interface
- CLK_HZ, 50_000_000, system clock frequency
- BAUD, 115_200, line rate; DIV = (CLK_HZ + BAUD/2) / BAUD clocks per bit (≥ 4)
- DATA_BITS, 8, payload bits per frame, legal 5..9
- PARITY, 0, 0 none, 1 odd, 2 even
- FIFO_DEPTH, 16, entries per FIFO, power of two ≥ 2
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- tx_data  in  DATA_BITS  word to transmit
- tx_valid  in  1  tx_data offered
- tx_ready  out  1  TX FIFO not full
- rx_data  out  DATA_BITS  head of RX FIFO (first-word fall-through)
- rx_valid  out  1  RX FIFO not empty
- rx_ready  in  1  consumer pops head
- tx_level / rx_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- tx  out  1  serial line out, idle high
- rx  in  1  serial line in, asynchronous
- tx_busy / rx_busy  out  1  frame in progress
- rx_overrun / rx_frame_err / rx_parity_err  out  1  sticky error flags
- err_clr  in  1  one-cycle pulse clears all sticky flags
- loopback  in  1  internal loopback select (see Configuration)

## Operation
- Frame: start (0), DATA_BITS data bits LSB first, parity bit if PARITY≠0, one stop (1). Odd parity makes the count of ones in data plus parity odd. Even parity makes it even.
- FIFOs:
  - Push on valid&ready, pop on valid&ready.
  - Push and pop in the same cycle leave the level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full = level==FIFO_DEPTH. Empty = level==0.
- TX FSM IDLE→START→DATA→(PARITY)→STOP→IDLE:
  - Each state holds for DIV clocks.
  - In IDLE with TX FIFO non-empty, the head is popped into the shifter and START is entered on the next cycle.
  - tx_busy is high in every state except IDLE.
- RX sync: rx passes through a 2-FF synchroniser. All RX decisions use the synchronised signal.
- RX FSM IDLE→START→DATA→(PARITY)→STOP→IDLE:
  - A falling edge in IDLE enters START.
  - At DIV/2 the line is resampled. If high, it was a glitch: return to IDLE with no flag.
  - Data, parity and stop bits are sampled every DIV clocks from the start-bit midpoint.
  - rx_busy is high in every state except IDLE.
- RX completion at the stop sample:
  - Stop=0: set rx_frame_err, discard the word.
  - Parity mismatch: set rx_parity_err, discard the word.
  - RX FIFO full: set rx_overrun, discard the word; FIFO contents are unchanged.
  - Otherwise push the word.
  - After any of these outcomes, return to IDLE; a new start bit is accepted immediately.
- Sticky flags: if err_clr and a set event occur in the same cycle, the set wins.

## Timing
- Reset (asynchronous, immediate):
  - tx=1, tx_busy=0, rx_busy=0.
  - tx_ready=1, rx_valid=0, rx_data=0, both levels=0, all flags=0.
  - Both FSMs return to IDLE and a frame in flight is abandoned.
  - On release, the RX synchroniser holds 1 and waits for a fresh falling edge.
- TX latency: word accepted at edge N → head visible at N+1 → tx falls at edge N+2. Frame length is (2+DATA_BITS+(PARITY≠0))·DIV clocks.
- Back-to-back TX: the next pop happens in the first IDLE cycle after STOP, giving one idle clock between frames.
- RX latency: rx_valid rises 3 clocks after the stop-bit midpoint on the rx pin (2 sync stages + 1 push).
- tx_ready is combinational from the FIFO level only; it does not depend on tx_valid.

## Configuration
- UART_LOOPBACK_EN defined: when loopback=1, the RX synchroniser input is the internal tx signal instead of the rx pin, and the tx pin is held at 1. When loopback=0, normal operation.
- UART_LOOPBACK_EN undefined: the loopback port exists but is ignored; RX always uses the rx pin and tx always drives the serializer.

## Test plan
- DATA_BITS=8, PARITY=0, DIV=434, push 0xA5 → tx bits 0,1,0,1,0,0,1,0,1,1, each 434 clocks; tx_busy high for 4340 clocks; tx_level returns to 0.
- UART_LOOPBACK_EN, loopback=1, push 0x00,0xFF,0x3C back-to-back, rx_ready=1 → rx_data pops 0x00,0xFF,0x3C in order; no flags set.
- FIFO_DEPTH=4, rx_ready=0, drive 5 valid frames on rx → rx_level=4 and rx_overrun=1. Pops return the first 4 words. An err_clr pulse clears rx_overrun.
- Drive frame 0x55 with stop bit 0 → no push (rx_level unchanged), rx_frame_err=1. A following good frame 0x12 is received correctly.
- PARITY=2, drive 0x07 with parity bit 0 → rx_parity_err=1, word discarded. Drive 0x07 with parity bit 1 → pushed, no new flag.
- FIFO_DEPTH=4, push 8 words with tx_valid held high, then assert rst_n=0 mid-frame → tx=1 and tx_level=0 immediately. After release, tx stays idle until a new push.
